// File: rtl/clk_ctrl_pkg.sv
// Shared types for the clock switch controller and its settle counter.
package clk_ctrl_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      RUN,
      SLEEP,
      DRAIN,
      SWITCH,
      RESUME,
      DONE
   } state_t;

endpackage

// File: rtl/clk_ctrl_cnt.sv
// Loadable down-counter with clear; tc is high while the count is zero.
module clk_ctrl_cnt
   import clk_ctrl_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock mux/gate sequencer: glitch-free source switch plus idle auto-gating.
module clk_switch_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int   SETTLE_CYC = 4,
   parameter int   IDLE_CYC   = 16,
   parameter int   CNT_W      = CNT_W_DEF,
   parameter logic RST_SEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_req,
   input  logic sw_sel,
   output logic sw_ack,
   output logic busy,
   input  logic auto_gate_en,
   input  logic idle_in,
   input  logic scan_en,
   output logic mux_sel_o,
   output logic gate_en_o,
   output logic gate_se_o,
   output logic sleeping
);

   state_t state, state_nx;
   logic tgt, tgt_nx;
   logic sel_nx, gate_nx, ack_nx, busy_nx, sleep_nx;
   logic [CNT_W-1:0] idle_cnt, idle_nx, idle_inc;
   logic settle_ld, settle_clr, settle_tc, idle_go;

   clk_ctrl_cnt #(.W(CNT_W)) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (settle_ld),
      .clear    (settle_clr),
      .load_val (CNT_W'(SETTLE_CYC - 1)),
      .tc       (settle_tc)
   );

   assign gate_se_o = scan_en;
   assign idle_go   = idle_in && auto_gate_en;
   assign idle_inc  = (idle_cnt == {CNT_W{1'b1}}) ? idle_cnt : idle_cnt + 1'b1;

   always_comb begin
      state_nx   = state;
      tgt_nx     = tgt;
      sel_nx     = mux_sel_o;
      gate_nx    = gate_en_o;
      ack_nx     = 1'b0;
      busy_nx    = busy;
      sleep_nx   = sleeping;
      idle_nx    = idle_cnt;
      settle_ld  = 1'b0;
      settle_clr = 1'b0;
      unique case (state)
         RUN, SLEEP: begin
            settle_clr = 1'b1;
            idle_nx    = idle_go ? idle_inc : '0;
            if (sw_req && sw_sel != mux_sel_o) begin
               state_nx  = DRAIN;
               tgt_nx    = sw_sel;
               gate_nx   = 1'b0;
               busy_nx   = 1'b1;
               sleep_nx  = 1'b0;
               idle_nx   = '0;
               settle_ld = 1'b1;
            end else if (sw_req) begin
               state_nx = RUN;
               gate_nx  = 1'b1;
               sleep_nx = 1'b0;
               ack_nx   = 1'b1;
               if (state == SLEEP) idle_nx = '0;
            end else if (state == SLEEP) begin
               if (!idle_go) begin
                  state_nx = RUN;
                  gate_nx  = 1'b1;
                  sleep_nx = 1'b0;
               end
            end else if (idle_go && idle_cnt == CNT_W'(IDLE_CYC - 1)) begin
               state_nx = SLEEP;
               gate_nx  = 1'b0;
               sleep_nx = 1'b1;
            end
         end
         DRAIN: begin
            if (settle_tc) begin
               state_nx  = SWITCH;
               sel_nx    = tgt;
               settle_ld = 1'b1;
            end
         end
         SWITCH: begin
            if (settle_tc) begin
               state_nx  = RESUME;
               gate_nx   = 1'b1;
               settle_ld = 1'b1;
            end
         end
         RESUME: begin
            if (settle_tc) begin
               state_nx   = DONE;
               ack_nx     = 1'b1;
               settle_clr = 1'b1;
            end
         end
         DONE: begin
            state_nx = RUN;
            busy_nx  = 1'b0;
            idle_nx  = '0;
         end
         default: begin
            state_nx = RUN;
            gate_nx  = 1'b1;
            busy_nx  = 1'b0;
            sleep_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         tgt       <= RST_SEL;
         mux_sel_o <= RST_SEL;
         gate_en_o <= 1'b1;
         sw_ack    <= 1'b0;
         busy      <= 1'b0;
         sleeping  <= 1'b0;
         idle_cnt  <= '0;
      end else begin
         state     <= state_nx;
         tgt       <= tgt_nx;
         mux_sel_o <= sel_nx;
         gate_en_o <= gate_nx;
         sw_ack    <= ack_nx;
         busy      <= busy_nx;
         sleeping  <= sleep_nx;
         idle_cnt  <= idle_nx;
      end
   end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed + random bench for clk_switch_ctrl with a cycle-stamped scoreboard.
module tb_clk_switch_ctrl;

   logic clk, rst;
   logic sw_req, sw_sel, sw_ack, busy;
   logic auto_gate_en, idle_in, scan_en;
   logic mux_sel_o, gate_en_o, gate_se_o, sleeping;

   // vector bits: {gate_se, mux_sel, gate_en, busy, ack, sleeping}
   localparam logic [5:0] M_ALL = 6'b111111;
   localparam logic [5:0] B_SE  = 6'b100000;

   typedef struct {
      int         cyc;
      string      tag;
      logic [5:0] exp;
      logic [5:0] mask;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   logic [5:0] obs;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic rst_edge = 1'b1;
   logic prev_ok = 1'b0;
   logic prev_sel, prev_gate;
   logic flush = 1'b0;
   int t, u, v;

   clk_switch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .sw_req       (sw_req),
      .sw_sel       (sw_sel),
      .sw_ack       (sw_ack),
      .busy         (busy),
      .auto_gate_en (auto_gate_en),
      .idle_in      (idle_in),
      .scan_en      (scan_en),
      .mux_sel_o    (mux_sel_o),
      .gate_en_o    (gate_en_o),
      .gate_se_o    (gate_se_o),
      .sleeping     (sleeping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= rst;
   end

   always @(negedge clk) begin
      obs = {gate_se_o, mux_sel_o, gate_en_o, busy, sw_ack, sleeping};
      while (sb.size() > 0 && (flush || sb[0].cyc <= cyc)) begin
         cur = sb.pop_front();
         checks++;
         assert (!flush && cur.cyc == cyc && (obs & cur.mask) === (cur.exp & cur.mask))
         else begin
            errors++;
            $error("FAIL %s @%0d: observed %b expected %b", cur.tag, cur.cyc,
                   obs & cur.mask, cur.exp & cur.mask);
         end
      end
      // select may only move while the gate is closed on both sides of the edge
      if (prev_ok && !rst_edge && mux_sel_o !== prev_sel) begin
         checks++;
         assert (prev_gate === 1'b0 && gate_en_o === 1'b0)
         else begin
            errors++;
            $error("FAIL sel_while_open @%0d: gate before %b after %b, required 0/0",
                   cyc, prev_gate, gate_en_o);
         end
      end
      prev_sel  = mux_sel_o;
      prev_gate = gate_en_o;
      prev_ok   = 1'b1;
   end

   task automatic exp_at(input int c, input string tag, input logic [5:0] e,
                         input logic [5:0] m);
      exp_t n;
      int i;
      n.cyc = c; n.tag = tag; n.exp = e; n.mask = m;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, n);
   endtask

   task automatic exp_rng(input int a, input int b, input string tag,
                          input logic [5:0] e);
      for (int c = a; c <= b; c++) exp_at(c, tag, e, M_ALL);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sw_req = 1'b0; sw_sel = 1'b0;
      auto_gate_en = 1'b0; idle_in = 1'b0; scan_en = 1'b0;
      exp_rng(1, 2, "reset", 6'b001000);
      tick(2);
      rst = 1'b0;
      t = cyc;
      exp_rng(t + 1, t + 20, "idle_run", 6'b001000);
      tick(20);

      // request for the already selected source
      t = cyc; sw_req = 1'b1; sw_sel = 1'b0;
      exp_at(t + 1, "match_ack", 6'b001010, M_ALL);
      exp_rng(t + 2, t + 4, "match_quiet", 6'b001000);
      tick(1); sw_req = 1'b0;
      tick(4);

      // extra requests during DRAIN, then reset mid-sequence
      t = cyc; sw_req = 1'b1; sw_sel = 1'b1;
      exp_rng(t + 1, t + 4, "drain", 6'b000100);
      exp_rng(t + 5, t + 6, "switch", 6'b010100);
      exp_at(t + 7, "rst_mid", 6'b001000, M_ALL);
      exp_rng(t + 8, t + 20, "post_rst", 6'b001000);
      tick(1); sw_req = 1'b0;
      tick(1); sw_req = 1'b1; sw_sel = 1'b0;
      tick(1); sw_sel = 1'b1;
      tick(1); sw_req = 1'b0;
      tick(2); rst = 1'b1;
      tick(1); rst = 1'b0;
      tick(13);

      // full switch 0 -> 1
      t = cyc; sw_req = 1'b1; sw_sel = 1'b1;
      exp_rng(t + 1, t + 4, "sw_drain", 6'b000100);
      exp_rng(t + 5, t + 8, "sw_switch", 6'b010100);
      exp_rng(t + 9, t + 12, "sw_resume", 6'b011100);
      exp_at(t + 13, "sw_ack", 6'b011110, M_ALL);
      exp_rng(t + 14, t + 16, "sw_done", 6'b011000);
      tick(1); sw_req = 1'b0;
      tick(15);

      // auto-gating and one-cycle wake
      t = cyc; auto_gate_en = 1'b1; idle_in = 1'b1;
      exp_rng(t + 1, t + 15, "idle_count", 6'b011000);
      exp_rng(t + 16, t + 20, "sleep", 6'b010001);
      exp_at(t + 21, "wake", 6'b011000, M_ALL);
      tick(20); idle_in = 1'b0;
      tick(2);

      // differing request while asleep, then re-sleep and matching request
      t = cyc; idle_in = 1'b1;
      exp_rng(t + 1, t + 15, "idle_count2", 6'b011000);
      exp_rng(t + 16, t + 18, "sleep2", 6'b010001);
      tick(18);
      u = cyc; sw_req = 1'b1; sw_sel = 1'b0;
      exp_rng(u + 1, u + 4, "slp_drain", 6'b010100);
      exp_rng(u + 5, u + 8, "slp_switch", 6'b000100);
      exp_rng(u + 9, u + 12, "slp_resume", 6'b001100);
      exp_at(u + 13, "slp_ack", 6'b001110, M_ALL);
      exp_rng(u + 14, u + 29, "reidle", 6'b001000);
      exp_rng(u + 30, u + 32, "resleep", 6'b000001);
      tick(1); sw_req = 1'b0;
      tick(31);
      v = cyc; sw_req = 1'b1; sw_sel = 1'b0;
      exp_at(v + 1, "slp_match", 6'b001010, M_ALL);
      exp_at(v + 2, "slp_match_run", 6'b001000, M_ALL);
      tick(1); sw_req = 1'b0; idle_in = 1'b0; auto_gate_en = 1'b0;
      tick(2);

      // scan mode passes through and does not disturb the sequence
      t = cyc; scan_en = 1'b1; sw_req = 1'b1; sw_sel = 1'b1;
      exp_at(t, "scan_se", 6'b100000, B_SE);
      exp_rng(t + 1, t + 4, "scan_drain", 6'b100100);
      exp_rng(t + 5, t + 8, "scan_switch", 6'b110100);
      exp_rng(t + 9, t + 12, "scan_resume", 6'b111100);
      exp_at(t + 13, "scan_ack", 6'b111110, M_ALL);
      exp_at(t + 14, "scan_done", 6'b011000, M_ALL);
      tick(1); sw_req = 1'b0;
      tick(13); scan_en = 1'b0;
      tick(1);

      // random traffic; the select/gate invariant is watched every cycle
      auto_gate_en = 1'b1;
      for (int k = 0; k < 400; k++) begin
         sw_req  = ($urandom_range(0, 9) == 0);
         sw_sel  = 1'($urandom_range(0, 1));
         scan_en = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) idle_in = ~idle_in;
         if ($urandom_range(0, 49) == 0) auto_gate_en = ~auto_gate_en;
         tick(1);
      end
      sw_req = 1'b0; idle_in = 1'b0; scan_en = 1'b0;

      for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
      flush = 1'b1;
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
